// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: synchronizes rx, frames 5-8 data bits with optional parity,
// and pushes each character with pe/fe/bi flags. Define UART_RX_MAJORITY_EN for 3-sample voting.
module uart_rx_deserializer #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_pulse_i,
    input  logic       rx_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sp_i,
    output logic [7:0] rx_data_o,
    output logic       rx_push_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       rx_busy_o
);

    localparam int unsigned TickW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [TickW-1:0] BitLast = TickW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TickW-1:0] StartLast = TickW'(OVERSAMPLE / 2);
`else
    localparam logic [TickW-1:0] StartLast = TickW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StPush,
        StWaitHigh
    } state_e;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_bit_q, par_bit_d;
    logic [1:0]         wls_q, wls_d;
    logic               pen_q, pen_d;
    logic               eps_q, eps_d;
    logic               sp_q, sp_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               pe_q, pe_d;
    logic               fe_q, fe_d;
    logic               bi_q, bi_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   bit_val;
    logic                   bit_sample;
    logic                   start_sample;
    logic                   last_bit;
    logic                   par_exp;

    // Stop-bit count only matters to the transmitter.
    logic unused_stb;
    assign unused_stb = stb_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q;

    // Two previous tick samples plus the current one form the vote.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vote_q <= 2'b11;
        end else if (baud_pulse_i) begin
            vote_q <= {vote_q[0], rxs};
        end
    end

    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    assign bit_sample   = baud_pulse_i && (tick_q == BitLast);
    assign start_sample = baud_pulse_i && (tick_q == StartLast);
    assign last_bit     = (bit_cnt_q == (3'd4 + {1'b0, wls_q}));
    assign par_exp      = sp_q ? ~eps_q : (eps_q ? ^shreg_q : ~^shreg_q);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        sp_d      = sp_q;
        rx_data_d = rx_data_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;

        unique case (state_q)
            StIdle: begin
                if (baud_pulse_i && !rxs) begin
                    state_d   = StStart;
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    par_bit_d = 1'b1;
                    wls_d     = wls_i;
                    pen_d     = pen_i;
                    eps_d     = eps_i;
                    sp_d      = sp_i;
                end
            end

            StStart: begin
                if (start_sample) begin
                    tick_d  = '0;
                    state_d = bit_val ? StIdle : StData;
                end else if (baud_pulse_i) begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StData: begin
                if (bit_sample) begin
                    tick_d             = '0;
                    shreg_d[bit_cnt_q] = bit_val;
                    if (last_bit) begin
                        state_d = pen_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (baud_pulse_i) begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StParity: begin
                if (bit_sample) begin
                    tick_d    = '0;
                    par_bit_d = bit_val;
                    state_d   = StStop;
                end else if (baud_pulse_i) begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StStop: begin
                if (bit_sample) begin
                    tick_d    = '0;
                    rx_data_d = shreg_q;
                    pe_d      = pen_q && (par_bit_q != par_exp);
                    fe_d      = !bit_val;
                    bi_d      = !bit_val && (shreg_q == 8'h00) && (!pen_q || !par_bit_q);
                    state_d   = StPush;
                end else if (baud_pulse_i) begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StPush: begin
                // A low stop bit may be a held break; wait for the line to recover.
                state_d = fe_q ? StWaitHigh : StIdle;
            end

            StWaitHigh: begin
                if (baud_pulse_i && rxs) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b1;
            wls_q     <= 2'b11;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            rx_data_q <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            sp_q      <= sp_d;
            rx_data_q <= rx_data_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
        end
    end

    assign rx_data_o = rx_data_q;
    assign pe_o      = pe_q;
    assign fe_o      = fe_q;
    assign bi_o      = bi_q;
    assign rx_push_o = (state_q == StPush);
    assign rx_busy_o = (state_q != StIdle);

endmodule
